// File: rtl/lcd_access_arbiter.sv
// Two-requester round-robin arbiter that serialises commands onto a single LCD
// encoder port, tracking the encoder busy handshake and timing out a silent encoder.
module lcd_access_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_Y_W = 6,
  parameter int ADDR_X_W = 3,
  parameter int ACTION_W = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                  i_clk_ctrl,
  input  logic                  i_reset,
  input  logic [1:0]            i_req,
  input  logic [2*DATA_W-1:0]   i_cmd_data,
  input  logic [2*ADDR_Y_W-1:0] i_cmd_addr_y,
  input  logic [2*ADDR_X_W-1:0] i_cmd_addr_x,
  input  logic [2*ACTION_W-1:0] i_cmd_action,
  output logic [1:0]            o_gnt,
  output logic [1:0]            o_done,
  output logic                  o_timeout_err,
  output logic [DATA_W-1:0]     o_data_write,
  output logic [ADDR_Y_W-1:0]   o_addr_y,
  output logic [ADDR_X_W-1:0]   o_addr_x,
  output logic [ACTION_W-1:0]   o_data_action,
  input  logic                  i_data_busy,
  input  logic                  i_instr_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_last_served;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [ACTION_W-1:0] r_action;

  logic                w_winner;
  logic [DATA_W-1:0]   w_sel_data;
  logic [ADDR_Y_W-1:0] w_sel_y;
  logic [ADDR_X_W-1:0] w_sel_x;
  logic [ACTION_W-1:0] w_sel_action;
  logic                w_start;

  // On a tie the requester that was not served last takes the slot.
  always_comb begin
    w_winner = 1'b0;
    case (i_req)
      2'b10:   w_winner = 1'b1;
      2'b11:   w_winner = ~r_last_served;
      default: w_winner = 1'b0;
    endcase
  end

  assign w_sel_data   = w_winner ? i_cmd_data[2*DATA_W-1:DATA_W]       : i_cmd_data[DATA_W-1:0];
  assign w_sel_y      = w_winner ? i_cmd_addr_y[2*ADDR_Y_W-1:ADDR_Y_W] : i_cmd_addr_y[ADDR_Y_W-1:0];
  assign w_sel_x      = w_winner ? i_cmd_addr_x[2*ADDR_X_W-1:ADDR_X_W] : i_cmd_addr_x[ADDR_X_W-1:0];
  assign w_sel_action = w_winner ? i_cmd_action[2*ACTION_W-1:ACTION_W] : i_cmd_action[ACTION_W-1:0];
  assign w_start      = (|i_req) && !i_data_busy && !i_instr_busy;

  always_ff @(posedge i_clk_ctrl) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_last_served <= 1'b1;
      r_wait_cnt    <= '0;
      r_action      <= '0;
      o_gnt         <= 2'b00;
      o_done        <= 2'b00;
      o_timeout_err <= 1'b0;
      o_data_write  <= '0;
      o_addr_y      <= '0;
      o_addr_x      <= '0;
      o_data_action <= '0;
    end else begin
      o_gnt         <= 2'b00;
      o_done        <= 2'b00;
      o_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state       <= ISSUE;
            r_owner       <= w_winner;
            r_action      <= w_sel_action;
            o_gnt         <= w_winner ? 2'b10 : 2'b01;
            o_data_write  <= w_sel_data;
            o_addr_y      <= w_sel_y;
            o_addr_x      <= w_sel_x;
            o_data_action <= w_sel_action;
          end
        end
        ISSUE: begin
          o_data_action <= '0;
          // A NOP never reaches the encoder, so complete it immediately.
          if (r_action == '0) begin
            r_state       <= IDLE;
            o_done        <= r_owner ? 2'b10 : 2'b01;
            r_last_served <= r_owner;
          end else begin
            r_state    <= WAIT_BUSY;
            r_wait_cnt <= '0;
          end
        end
        WAIT_BUSY: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (i_data_busy) begin
            r_state <= WAIT_DONE;
          end else if (r_wait_cnt == CNT_LAST) begin
            r_state       <= IDLE;
            o_done        <= r_owner ? 2'b10 : 2'b01;
            o_timeout_err <= 1'b1;
            r_last_served <= r_owner;
          end
        end
        WAIT_DONE: begin
          if (!i_data_busy) begin
            r_state       <= IDLE;
            o_done        <= r_owner ? 2'b10 : 2'b01;
            r_last_served <= r_owner;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_access_arbiter.sv
// Directed bench for lcd_access_arbiter: handshake, round-robin, stalls,
// timeout, NOP commands and mid-operation reset.
module tb_lcd_access_arbiter;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] cmd_data;
  logic [11:0] cmd_y;
  logic [5:0]  cmd_x;
  logic [3:0]  cmd_act;
  logic [1:0]  gnt, done;
  logic        terr;
  logic [7:0]  dw;
  logic [5:0]  ay;
  logic [2:0]  ax;
  logic [1:0]  da;
  logic        data_busy, instr_busy;

  int tests = 0;
  int fails = 0;
  int overlap_err = 0;

  lcd_access_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .i_clk_ctrl(clk), .i_reset(reset), .i_req(req),
    .i_cmd_data(cmd_data), .i_cmd_addr_y(cmd_y), .i_cmd_addr_x(cmd_x),
    .i_cmd_action(cmd_act), .o_gnt(gnt), .o_done(done),
    .o_timeout_err(terr), .o_data_write(dw), .o_addr_y(ay), .o_addr_x(ax),
    .o_data_action(da), .i_data_busy(data_busy), .i_instr_busy(instr_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && (((|gnt) && (|done)) || gnt == 2'b11 || done == 2'b11))
      overlap_err++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 10; i++) begin
      if (|gnt) break;
      tick();
    end
    chk(tag, gnt, exp);
  endtask

  // From the ISSUE cycle: encoder goes busy for one cycle, then releases.
  task automatic finish_cmd(input string tag, input logic [1:0] exp);
    tick();
    data_busy = 1'b1;
    tick();
    data_busy = 1'b0;
    tick();
    chk(tag, {29'd0, terr, done}, {29'd0, 1'b0, exp});
  endtask

  initial begin
    int seen;
    reset = 1'b1; req = 2'b00; data_busy = 1'b0; instr_busy = 1'b0;
    cmd_data = {8'h3C, 8'hA5}; cmd_y = {6'd9, 6'd5}; cmd_x = {3'd6, 3'd2};
    cmd_act = {2'd2, 2'd1};
    tick(); tick();
    chk("rst_ctl", {gnt, done, terr}, 5'b0);
    chk("rst_dat", {dw, ay, ax, da}, 19'b0);
    reset = 1'b0;
    tick();
    chk("idle_gnt", gnt, 2'b00);

    // Single request from requester 0, encoder busy 3 cycles after issue for 10
    req = 2'b01;
    tick();
    chk("s_gnt", gnt, 2'b01);
    chk("s_act", da, 2'd1);
    chk("s_fields", {dw, ay, ax}, {8'hA5, 6'd5, 3'd2});
    req = 2'b00;
    tick();
    chk("s_act_off", da, 2'd0);
    tick(); tick();
    data_busy = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); seen |= int'(|done); end
    chk("s_nodone_busy", seen, 0);
    data_busy = 1'b0;
    tick();
    chk("s_done", done, 2'b01);
    chk("s_hold", {dw, ay, ax}, {8'hA5, 6'd5, 3'd2});
    tick();
    chk("s_done_off", done, 2'b00);

    // NOP from requester 1
    cmd_act = {2'd0, 2'd1};
    req = 2'b10;
    tick();
    chk("nop_gnt", gnt, 2'b10);
    chk("nop_act", da, 2'd0);
    chk("nop_dat", dw, 8'h3C);
    req = 2'b00;
    tick();
    chk("nop_done", done, 2'b10);
    chk("nop_act2", da, 2'd0);
    tick();

    // Both requesting across three transactions
    cmd_act = {2'd2, 2'd1};
    req = 2'b11;
    wait_gnt("rr_g0", 2'b01);
    finish_cmd("rr_d0", 2'b01);
    wait_gnt("rr_g1", 2'b10);
    chk("rr_dat1", {dw, da}, {8'h3C, 2'd2});
    finish_cmd("rr_d1", 2'b10);
    wait_gnt("rr_g2", 2'b01);
    finish_cmd("rr_d2", 2'b01);
    req = 2'b00;
    tick();

    // Instruction path busy stalls the grant
    instr_busy = 1'b1;
    req = 2'b10;
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); seen |= int'(|gnt); end
    chk("ib_nognt", seen, 0);
    instr_busy = 1'b0;
    tick();
    chk("ib_gnt", gnt, 2'b10);
    req = 2'b00;
    finish_cmd("ib_done", 2'b10);

    // Encoder never responds
    cmd_act = {2'd1, 2'd3};
    req = 2'b01;
    wait_gnt("to_gnt", 2'b01);
    req = 2'b00;
    tick();
    seen = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin seen |= int'(|done); tick(); end
    seen |= int'(|done);
    chk("to_early", seen, 0);
    tick();
    chk("to_done", {29'd0, terr, done}, {29'd0, 1'b1, 2'b01});
    tick();
    chk("to_clear", {29'd0, terr, done}, 32'd0);
    req = 2'b01;
    wait_gnt("to_next_gnt", 2'b01);
    req = 2'b00;
    finish_cmd("to_next_done", 2'b01);

    // Reset during WAIT_DONE, then tie must go to requester 0
    req = 2'b11;
    wait_gnt("rs_gnt", 2'b10);
    req = 2'b00;
    tick();
    data_busy = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rs_ctl", {gnt, done, terr}, 5'b0);
    chk("rs_dat", {dw, ay, ax, da}, 19'b0);
    reset = 1'b0;
    data_busy = 1'b0;
    tick();
    chk("rs_nodone", done, 2'b00);
    req = 2'b11;
    wait_gnt("rs_tie", 2'b01);
    req = 2'b00;
    finish_cmd("rs_fin", 2'b01);

    chk("no_overlap", overlap_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
